// File: rtl/rptr_aempty_lvl.sv
// Read-side pointer/status for the async FIFO: binary and Gray read pointers,
// registered empty, almost-empty, fill level and sticky underflow.
module rptr_aempty_lvl #(
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    input  logic                  runderflow_clr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  runderflow
);

    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic [PW-1:0] wbin;
    logic          rempty_q, rempty_d;
    logic          raempty_q, raempty_d;
    logic          runderflow_q, runderflow_d;
    logic          rpop;

    always_comb begin
        wbin = '0;
        wbin[PW-1] = rq2_wptr[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ rq2_wptr[i];
        end
    end

    always_comb begin
        rpop       = rinc & ~rempty_q;
        rbin_d     = rbin_q + {{(PW-1){1'b0}}, rpop};
        rptr_d     = (rbin_d >> 1) ^ rbin_d;
        rempty_d   = (rptr_d == rq2_wptr);
        // Modulo subtraction keeps the level correct across pointer wrap.
        rlevel_d   = wbin - rbin_d;
        raempty_d  = (rlevel_d <= THRESH);
        // A new underflow takes priority over a simultaneous clear.
        runderflow_d = (rinc & rempty_q) | (runderflow_q & ~runderflow_clr);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rlevel_q     <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rlevel_q     <= rlevel_d;
            rempty_q     <= rempty_d;
            raempty_q    <= raempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign raddr      = rbin_q[ADDR_WIDTH-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign raempty    = raempty_q;
    assign rlevel     = rlevel_q;
    assign runderflow = runderflow_q;

endmodule

// File: tb/tb_rptr_aempty_lvl.sv
// Bench for rptr_aempty_lvl: directed vector table, wrap stream, random traffic
// against an integer read/write-count model, and asynchronous mid-stream reset.
module tb_rptr_aempty_lvl;

    localparam int unsigned AW = 3;
    localparam int unsigned TH = 2;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          rinc;
    logic [AW:0]   rq2_wptr;
    logic          runderflow_clr;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rlevel;
    logic          runderflow;

    rptr_aempty_lvl #(.ADDR_WIDTH(AW), .AEMPTY_THRESH(TH)) dut (
        .rclk           (rclk),
        .rrst_n         (rrst_n),
        .rinc           (rinc),
        .rq2_wptr       (rq2_wptr),
        .runderflow_clr (runderflow_clr),
        .raddr          (raddr),
        .rptr           (rptr),
        .rempty         (rempty),
        .raempty        (raempty),
        .rlevel         (rlevel),
        .runderflow     (runderflow)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    // Model: total reads done and pre-edge flags, all plain integers.
    int m_rd;
    int m_level;
    bit m_empty;
    bit m_aempty;
    bit m_uf;
    logic [AW:0] prev_ptr;
    bit seen_wrap;

    typedef struct {
        bit inc;
        bit clr;
        int wcnt;
        int lvl;
        bit emp;
        bit aemp;
        int addr;
        int ptr;
        bit uf;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [AW:0] gray(input int n);
        logic [AW:0] b;
        b = (AW+1)'(n % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd = 0; m_level = 0; m_empty = 1; m_aempty = 1; m_uf = 0;
        prev_ptr = '0;
    endtask

    task automatic model_step(input bit inc, input bit clr, input int wcnt);
        bit pop;
        pop = inc && !m_empty;
        if (inc && m_empty) m_uf = 1;
        else if (clr) m_uf = 0;
        if (pop) m_rd++;
        m_level  = wcnt - m_rd;
        m_empty  = (m_level == 0);
        m_aempty = (m_level <= int'(TH));
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rlevel"},     int'(rlevel),     m_level);
        chk({tag, "_rempty"},     int'(rempty),     int'(m_empty));
        chk({tag, "_raempty"},    int'(raempty),    int'(m_aempty));
        chk({tag, "_raddr"},      int'(raddr),      m_rd % 8);
        chk({tag, "_rptr"},       int'(rptr),       int'(gray(m_rd)));
        chk({tag, "_runderflow"}, int'(runderflow), int'(m_uf));
    endtask

    task automatic cycle(input bit inc, input bit clr, input int wcnt, input string tag);
        rinc = inc;
        runderflow_clr = clr;
        rq2_wptr = gray(wcnt);
        @(posedge rclk);
        model_step(inc, clr, wcnt);
        #1;
        if (tag != "") check_model(tag);
        chk("gray_one_bit", int'($countones(rptr ^ prev_ptr) <= 1), 1);
        if (prev_ptr == 4'b1000 && rptr == 4'b0000) seen_wrap = 1;
        prev_ptr = rptr;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rempty"},     int'(rempty),     1);
        chk({tag, "_raempty"},    int'(raempty),    1);
        chk({tag, "_rlevel"},     int'(rlevel),     0);
        chk({tag, "_rptr"},       int'(rptr),       0);
        chk({tag, "_raddr"},      int'(raddr),      0);
        chk({tag, "_runderflow"}, int'(runderflow), 0);
    endtask

    initial begin
        int wc;
        tbl[0]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 1, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 5, 5, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 5, 4, 0, 0, 1, 4'b0001, 0};
        tbl[4]  = '{1, 0, 5, 3, 0, 0, 2, 4'b0011, 0};
        tbl[5]  = '{1, 0, 5, 2, 0, 1, 3, 4'b0010, 0};
        tbl[6]  = '{1, 0, 5, 1, 0, 1, 4, 4'b0110, 0};
        tbl[7]  = '{1, 0, 5, 0, 1, 1, 5, 4'b0111, 0};
        tbl[8]  = '{1, 0, 5, 0, 1, 1, 5, 4'b0111, 1};
        tbl[9]  = '{0, 0, 5, 0, 1, 1, 5, 4'b0111, 1};
        tbl[10] = '{0, 1, 5, 0, 1, 1, 5, 4'b0111, 0};
        tbl[11] = '{1, 1, 5, 0, 1, 1, 5, 4'b0111, 1};
        tbl[12] = '{0, 0, 5, 0, 1, 1, 5, 4'b0111, 1};
        tbl[13] = '{0, 1, 5, 0, 1, 1, 5, 4'b0111, 0};

        rrst_n = 1'b0;
        rinc = 1'b0;
        runderflow_clr = 1'b0;
        rq2_wptr = '0;
        seen_wrap = 0;
        model_reset();
        #12;
        check_reset_vals("reset");
        rrst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].inc, tbl[i].clr, tbl[i].wcnt, "");
            chk($sformatf("vec%0d_rlevel", i),     int'(rlevel),     tbl[i].lvl);
            chk($sformatf("vec%0d_rempty", i),     int'(rempty),     int'(tbl[i].emp));
            chk($sformatf("vec%0d_raempty", i),    int'(raempty),    int'(tbl[i].aemp));
            chk($sformatf("vec%0d_raddr", i),      int'(raddr),      tbl[i].addr);
            chk($sformatf("vec%0d_rptr", i),       int'(rptr),       tbl[i].ptr);
            chk($sformatf("vec%0d_runderflow", i), int'(runderflow), int'(tbl[i].uf));
        end

        // Wrap stream: get three ahead, then write and pop together across 16.
        wc = 5;
        for (int i = 0; i < 3; i++) begin
            wc++;
            cycle(0, 0, wc, "prefill");
        end
        for (int i = 0; i < 20; i++) begin
            wc++;
            cycle(1, 0, wc, "wrap");
            chk("wrap_level_max", int'(rlevel <= 8), 1);
        end
        chk("wrap_seen", int'(seen_wrap), 1);

        for (int i = 0; i < 400; i++) begin
            bit inc, clr;
            inc = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1 && (wc - m_rd) < 8) wc++;
            cycle(inc, clr, wc, "rand");
        end

        // Drain, then build a level of four for the mid-stream reset.
        for (int i = 0; i < 20; i++) begin
            if (!m_empty) cycle(1, 0, wc, "drain");
        end
        cycle(0, 1, wc, "drain_clr");
        for (int i = 0; i < 4; i++) begin
            wc++;
            cycle(0, 0, wc, "refill");
        end
        chk("pre_reset_rlevel", int'(rlevel), 4);
        rinc = 1'b1;
        #2;
        rrst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        rinc = 1'b0;
        rq2_wptr = '0;
        model_reset();
        #1;
        rrst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
